mem_wb_stage: RTL
=================

# mem_wb_stage

Memory stage of the 16-bit pipeline, directly downstream of the EX write-data selector. It holds the EX/MEM register and issues loads and stores to the data-memory/cache port using a req/done handshake. It stalls EX while an access is outstanding. It produces the registered MEM/WB write-back bundle, choosing the EX write data or, for loads, the memory read data. Misaligned accesses, memory errors and access timeouts set a sticky error.

## Interface
Parameters:
- TIMEOUT, 64, maximum number of request cycles allowed without `dmem_done`; must be ≥2.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  combinational; the stage accepts the instruction this cycle.
- ex_writedata  in  16  EX-selected write-back data.
- ex_wrt_dmem  in  1  load; write-back data comes from memory.
- ex_mem_write  in  1  store.
- ex_addr  in  16  memory address (ALU result).
- ex_store_data  in  16  store data.
- ex_reg_write  in  1  instruction writes the register file.
- ex_wb_reg  in  3  destination register.
- dmem_req  out  1  access request.
- dmem_wr  out  1  1 = store, 0 = load.
- dmem_addr  out  16  access address.
- dmem_wdata  out  16  store data.
- dmem_done  in  1  access complete this cycle.
- dmem_rdata  in  16  load data; valid when `dmem_done` is high.
- dmem_err  in  1  access fault; sampled only while `dmem_req` is high.
- wb_valid  out  1  write-back bundle is valid for one cycle.
- wb_reg_write  out  1  register-file write enable.
- wb_reg  out  3  destination register.
- wb_data  out  16  write-back data.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 01 = dmem_err, 10 = misaligned, 11 = timeout.

## Operation
- **EX/MEM register** fields: m_valid, m_load, m_store, m_mis, m_addr, m_sdata, m_wdata, m_rw, m_reg.
  - Loaded when `ex_valid & ex_ready`.
  - Otherwise m_valid clears when the held instruction completes, and all fields hold while it is stalled.
  - m_mis = (load|store) & ex_addr[0]. All memory accesses are word-aligned.
- **Completion:** m_mem = m_load | m_store. m_complete = m_valid & (!m_mem | (dmem_done & !dmem_err)) & !m_mis & !err.
- **Ready:** ex_ready = !err & (!m_valid | m_complete). A completing instruction and a new one transfer in the same cycle.
- **Memory request:** dmem_req = m_valid & m_mem & !m_mis & !err.
  - dmem_wr = m_store, dmem_addr = m_addr, dmem_wdata = m_sdata.
  - All four stay stable while `dmem_req` is high.
- **Write-back register:** loaded every cycle.
  - wb_valid <= m_complete.
  - wb_data <= m_load ? dmem_rdata : m_wdata.
  - wb_reg_write <= m_complete & m_rw & !m_store.
  - wb_reg <= m_reg.
  - When `m_complete` is 0, wb_valid and wb_reg_write are 0; wb_data and wb_reg hold their previous values.
- **Error FSM:** states RUN and ERR.
  - RUN→ERR when m_mis & m_valid (code 10).
  - RUN→ERR when dmem_req & dmem_err (code 01). `dmem_err` wins over a simultaneous `dmem_done`, and that instruction produces no write-back.
  - RUN→ERR on timeout (code 11).
  - ERR persists until `rst`. In ERR: dmem_req=0, ex_ready=0, no write-backs, err=1.
- **Timeout counter:** width $clog2(TIMEOUT).
  - Cleared when dmem_req=0 or on dmem_done.
  - Otherwise increments each cycle that dmem_req & !dmem_done.
  - If the counter equals TIMEOUT-1 and `dmem_done` is low in that cycle, go to ERR at the next edge. A done arriving in request cycle TIMEOUT (counter = TIMEOUT-1) is still accepted.
- `dmem_done` or `dmem_err` while `dmem_req` is low: ignored.

## Timing
- **Reset values:**
  - All registers are 0, so m_valid=0 and the FSM is in RUN.
  - Outputs after the reset edge: ex_ready=1; dmem_req, dmem_wr, dmem_addr, dmem_wdata = 0; wb_valid, wb_reg_write, wb_reg, wb_data = 0; err=0, err_code=00.
- Reset mid-access drops the outstanding request in the next cycle, with no write-back. A later `dmem_done` is ignored.
- **Non-memory instruction:** accepted at edge k, in M during cycle k..k+1, wb_valid high for the cycle after edge k+1. Throughput is one per cycle.
- **Memory instruction:**
  - `dmem_req` rises in the cycle after acceptance.
  - If `dmem_done` comes d cycles after req rises (d=0 means the same cycle), wb_valid is high after edge k+1+d.
  - ex_ready is low during cycles k+1..k+d, and high in the done cycle.
- **Misaligned access:** accepted at edge k; err=1 after edge k+1. `dmem_req` never asserts.

## Test plan
- Three back-to-back ALU ops writing 0x1111, 0x2222, 0x3333 to r1, r2, r3 → wb_valid high on 3 consecutive cycles with matching data and registers; ex_ready stays 1.
- Load from addr 0x0040, memory answers done=1 with rdata=0xBEEF on the 3rd request cycle → ex_ready=0 for 2 cycles, req/addr stable, then wb_data=0xBEEF, wb_reg_write=1. The next ALU op follows the load without a bubble.
- Store of 0xA5A5 to 0x0010 with reg_write=1 and done in the same cycle → dmem_wr=1, dmem_wdata=0xA5A5; wb_valid=1 with wb_reg_write=0.
- Load to 0x0041 → no dmem_req; err=1, err_code=10; ex_ready=0 until rst; after rst, all outputs return to 0.
- TIMEOUT=4, done never asserted → req high 4 cycles, then err=1, err_code=11. Repeat with done in the 4th cycle → normal write-back, no error.
- dmem_err and dmem_done together on a load → err_code=01, no wb_valid. Separately, rst asserted mid-request → req=0 next cycle; a later done produces no write-back.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory stage of the 16-bit pipeline. Holds the EX/MEM register, issues loads
// and stores to the data-memory port over a req/done handshake, stalls EX
// while an access is outstanding, and produces the registered MEM/WB
// write-back bundle. Misaligned accesses, memory faults and access timeouts
// drive the stage into a sticky error state that only rst leaves.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ex_*                instruction presented by EX; ex_ready is combinational
//   dmem_req/wr/addr/wdata  request to data memory (stable while req is high)
//   dmem_done/rdata/err     response from data memory (ignored while req low)
//   wb_*                registered write-back bundle, wb_valid is a 1-cycle pulse
//   err, err_code       sticky error flag and cause (01 fault, 10 misaligned,
//                       11 timeout)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] ex_writedata,
    input  logic        ex_wrt_dmem,
    input  logic        ex_mem_write,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_store_data,
    input  logic        ex_reg_write,
    input  logic [2:0]  ex_wb_reg,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_done,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    // EX/MEM register
    logic        m_valid_r;
    logic        m_load_r;
    logic        m_store_r;
    logic        m_mis_r;
    logic [15:0] m_addr_r;
    logic [15:0] m_sdata_r;
    logic [15:0] m_wdata_r;
    logic        m_rw_r;
    logic [2:0]  m_reg_r;

    // MEM/WB register
    logic        wb_valid_r;
    logic        wb_reg_write_r;
    logic [2:0]  wb_reg_r;
    logic [15:0] wb_data_r;

    // Error FSM and timeout counter
    state_t           state_r;
    state_t           state_nx_s;
    logic [1:0]       err_code_r;
    logic [1:0]       err_code_nx_s;
    logic [CNT_W-1:0] tmo_cnt_r;

    logic err_s;
    logic m_mem_s;
    logic m_complete_s;
    logic ex_ready_s;
    logic accept_s;
    logic dmem_req_s;
    logic tmo_hit_s;

    assign err_s   = (state_r == ST_ERR);
    assign m_mem_s = m_load_r | m_store_r;

    // A memory instruction finishes only on a clean done; a fault wins over
    // a simultaneous done, and nothing completes once the stage is in error.
    assign m_complete_s = m_valid_r & (~m_mem_s | (dmem_done & ~dmem_err))
                        & ~m_mis_r & ~err_s;

    assign ex_ready_s = ~err_s & (~m_valid_r | m_complete_s);
    assign accept_s   = ex_valid & ex_ready_s;
    assign dmem_req_s = m_valid_r & m_mem_s & ~m_mis_r & ~err_s;

    // Counter holds TIMEOUT-1 during the last allowed request cycle; a done
    // in that cycle is still accepted.
    assign tmo_hit_s = dmem_req_s & ~dmem_done & (tmo_cnt_r == CNT_LAST);

    assign ex_ready     = ex_ready_s;
    assign dmem_req     = dmem_req_s;
    assign dmem_wr      = m_store_r;
    assign dmem_addr    = m_addr_r;
    assign dmem_wdata   = m_sdata_r;
    assign wb_valid     = wb_valid_r;
    assign wb_reg_write = wb_reg_write_r;
    assign wb_reg       = wb_reg_r;
    assign wb_data      = wb_data_r;
    assign err          = err_s;
    assign err_code     = err_code_r;

    // EX/MEM register: load on transfer, retire on completion, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_load_r  <= 1'b0;
            m_store_r <= 1'b0;
            m_mis_r   <= 1'b0;
            m_addr_r  <= 16'h0000;
            m_sdata_r <= 16'h0000;
            m_wdata_r <= 16'h0000;
            m_rw_r    <= 1'b0;
            m_reg_r   <= 3'b000;
        end else if (accept_s) begin
            m_valid_r <= 1'b1;
            m_load_r  <= ex_wrt_dmem;
            m_store_r <= ex_mem_write;
            m_mis_r   <= (ex_wrt_dmem | ex_mem_write) & ex_addr[0];
            m_addr_r  <= ex_addr;
            m_sdata_r <= ex_store_data;
            m_wdata_r <= ex_writedata;
            m_rw_r    <= ex_reg_write;
            m_reg_r   <= ex_wb_reg;
        end else if (m_complete_s) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Write-back register: valid pulses per completion, payload held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
            wb_reg_r       <= 3'b000;
            wb_data_r      <= 16'h0000;
        end else begin
            wb_valid_r     <= m_complete_s;
            wb_reg_write_r <= m_complete_s & m_rw_r & ~m_store_r;
            if (m_complete_s) begin
                wb_data_r <= m_load_r ? dmem_rdata : m_wdata_r;
                wb_reg_r  <= m_reg_r;
            end else begin
                wb_data_r <= wb_data_r;
                wb_reg_r  <= wb_reg_r;
            end
        end
    end

    // Request-cycle counter for the outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (!dmem_req_s || dmem_done) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end

    // Error FSM state and cause register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            err_code_r <= 2'b00;
        end else begin
            state_r    <= state_nx_s;
            err_code_r <= err_code_nx_s;
        end
    end

    // Error FSM next state; misalignment and request cannot coincide, and a
    // memory fault takes priority over a timeout in the same cycle.
    always_comb begin
        state_nx_s    = state_r;
        err_code_nx_s = err_code_r;
        case (state_r)
            ST_RUN: begin
                if (m_valid_r && m_mis_r) begin
                    state_nx_s    = ST_ERR;
                    err_code_nx_s = 2'b10;
                end else if (dmem_req_s && dmem_err) begin
                    state_nx_s    = ST_ERR;
                    err_code_nx_s = 2'b01;
                end else if (tmo_hit_s) begin
                    state_nx_s    = ST_ERR;
                    err_code_nx_s = 2'b11;
                end else begin
                    state_nx_s    = ST_RUN;
                    err_code_nx_s = err_code_r;
                end
            end
            ST_ERR: begin
                state_nx_s    = ST_ERR;
                err_code_nx_s = err_code_r;
            end
            default: begin
                state_nx_s    = ST_ERR;
                err_code_nx_s = err_code_r;
            end
        endcase
    end

endmodule
